mode_ctrl: RTL and testbench
============================

Name: mode_ctrl

Overview:
- Front-panel mode controller directly upstream of the text LCD driver.
- Conditions two raw push-buttons (next, prev): 2-flop synchronise, debounce, rising-edge detect.
- Runs a 4-state mode FSM and drives the registered 2-bit msg_sel consumed by the LCD driver, plus a one-hot mode bus and a mode-change strobe for the watch/stopwatch/timer datapaths.

Parameters:
- DEB_CYCLES, 1000, consecutive clk samples a synchronised button must differ from its stable level before the stable level flips (≥2).
- LONG_CYCLES, 200000, clk cycles a debounced next must stay high before the long-press home action fires (≥2).

Ports:
- clk  in  1  system clock (same clk the LCD driver divides)
- rst  in  1  reset; asynchronous, active-high
- btn_next  in  1  raw, asynchronous, active-high "next mode" button
- btn_prev  in  1  raw, asynchronous, active-high "previous mode" button
- msg_sel  out  2  current mode code to LCD driver, registered
- mode_onehot  out  4  one-hot decode of msg_sel, registered; bit n set when msg_sel==n
- mode_chg  out  1  one-cycle pulse on the edge msg_sel takes a new value

Behaviour:
- Reset values: msg_sel=2'b00, mode_onehot=4'b0001, mode_chg=0. All synchroniser flops, stable levels, debounce counters, press pulses and the long counter are 0.
- Synchroniser: two flops per button; the counter sees only the second-flop output.
- Debounce, per button:
  - Counter increments on every edge where sync!=stable, and clears on any edge where sync==stable.
  - When the count reaches DEB_CYCLES, stable flips and the counter clears.
  - Counter width is $clog2(DEB_CYCLES+1).
- Press pulse: registered stable & ~stable_prev, high for exactly 1 cycle per debounced rising edge. Falling edges produce nothing.
- Latency: raw button first sampled high at edge k and held → msg_sel/mode_chg update at edge k+DEB_CYCLES+3.
- Mode FSM states: WATCH=00, STOPWATCH=01, TIMER=10, INFO=11.
  - next press: state+1, wrapping 11→00.
  - prev press: state−1, wrapping 00→11.
  - next and prev press pulses in the same cycle: both ignored; no change, no mode_chg.
  - mode_chg=1 on exactly the edge msg_sel changes, otherwise 0.
  - mode_onehot always updates on the same edge as msg_sel.
- Long press (macro below):
  - Long counter clears while debounced next is low and increments while it is high, saturating at LONG_CYCLES.
  - On the edge it reaches LONG_CYCLES: state→WATCH with mode_chg=1.
  - If already WATCH, no change and no pulse.
  - Fires at most once per hold.
  - A prev press in the same cycle is overridden by the long action.
- Reset mid-operation: all in-flight debounce/long counts are discarded. A button held through reset deassertion is treated as a fresh press (stable=0, sync=1) and advances the mode after the normal debounce latency.
- Bounce shorter than DEB_CYCLES consecutive samples never changes the stable level.

Optional Feature:
- MODE_CTRL_LONG_HOME_EN defined: long counter and long-press home action are present as described.
- Undefined: no long counter is instantiated. A held next button produces exactly one advance; msg_sel changes only on next/prev presses.

Decomposition:
- Shared package/include mode_defs holds the mode encodings MODE_WATCH=2'b00, MODE_STOPWATCH=2'b01, MODE_TIMER=2'b10, MODE_INFO=2'b11. The LCD driver's msg_sel case decoding uses the same constants.
- One sub-module, btn_debounce (params DEB_CYCLES; ports clk, rst, raw, level, press), instantiated twice.
- FSM, long counter and output registers live in mode_ctrl.

Test Plan (DEB_CYCLES=4, LONG_CYCLES=50):
- Reset: assert rst mid-run → msg_sel=00, mode_onehot=0001, mode_chg=0 immediately (async), held after release with buttons low.
- Clean next press: raw high 20 cycles from edge k → msg_sel 00→01 and mode_chg=1 exactly at edge k+7. Four presses return msg_sel to 00, with four single-cycle pulses total.
- Bounce: btn_next toggles every 2 cycles for 30 cycles, then low → msg_sel unchanged, mode_chg never asserted.
- prev wrap and simultaneous presses: from 00, a prev press → 11, onehot 1000. Then next and prev raised on the same edge for 20 cycles → stays 11, no pulse.
- Long press (macro on): from TIMER, hold next 80 cycles → 11 at k+7, then 00 with a second mode_chg pulse 50 cycles after the debounced rise. Nothing further until release. Same stimulus with the macro off → ends at 11 with a single pulse.
- Reset during hold: next high, rst pulsed at cycle 3 of debounce, next kept high → exactly one advance to 01, DEB_CYCLES+3 edges after rst release.

Source files
------------

// File: rtl/mode_defs.sv
`default_nettype none
// ============================================================================
// Module : mode_defs (package)
// Brief  : Mode encodings shared by mode_ctrl and the LCD driver msg_sel decode
// Rev    : 1.0
// ============================================================================
package mode_defs;

    typedef enum logic [1:0] {
        MODE_WATCH     = 2'b00,
        MODE_STOPWATCH = 2'b01,
        MODE_TIMER     = 2'b10,
        MODE_INFO      = 2'b11
    } mode_e;

    function automatic logic [3:0] mode_onehot_f(input mode_e m);
        return 4'b0001 << m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mode_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module : btn_debounce
// Brief  : 2-flop synchroniser, counter debounce and rising-edge press pulse
// Rev    : 1.0
// ============================================================================
module btn_debounce #(
    parameter int DEB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          stable_prev_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // The stable level flips on the DEB_CYCLES-th consecutive differing sample.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            cnt_d    = '0;
            stable_d = ~stable_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            press_q       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= raw;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            press_q       <= stable_q & ~stable_prev_q;
            cnt_q         <= cnt_d;
        end
    end

    assign level = stable_q;
    assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mode_ctrl
// Brief  : Front-panel mode FSM; MODE_CTRL_LONG_HOME_EN adds long-press home
// Rev    : 1.0
// ============================================================================
module mode_ctrl
    import mode_defs::*;
#(
    parameter int DEB_CYCLES  = 1000,
    parameter int LONG_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_prev,
    output logic [1:0] msg_sel,
    output logic [3:0] mode_onehot,
    output logic       mode_chg
);

    logic  next_level, next_press;
    logic  prev_level, prev_press;
    logic  long_fire;
    mode_e mode_q, mode_d;
    logic [3:0] onehot_q;
    logic       chg_q;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_next),
        .level (next_level),
        .press (next_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prev (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_prev),
        .level (prev_level),
        .press (prev_press)
    );

`ifdef MODE_CTRL_LONG_HOME_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);
    logic [LW-1:0] long_q, long_d;

    // Saturation at LONG_CYCLES is what limits the home action to once per hold.
    always_comb begin
        long_d = long_q;
        if (!next_level)
            long_d = '0;
        else if (long_q != LW'(LONG_CYCLES))
            long_d = long_q + 1'b1;
    end

    assign long_fire = next_level && (long_q == LW'(LONG_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) long_q <= '0;
        else     long_q <= long_d;
    end

    logic unused_levels;
    assign unused_levels = prev_level;
`else
    assign long_fire = 1'b0;

    logic unused_levels;
    assign unused_levels = &{1'b0, next_level, prev_level};
`endif

    // Long-press home has priority; coincident next/prev presses cancel.
    always_comb begin
        mode_d = mode_q;
        if (long_fire)
            mode_d = MODE_WATCH;
        else if (next_press && !prev_press)
            mode_d = mode_e'(2'(mode_q + 2'd1));
        else if (prev_press && !next_press)
            mode_d = mode_e'(2'(mode_q - 2'd1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= MODE_WATCH;
            onehot_q <= 4'b0001;
            chg_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            onehot_q <= mode_onehot_f(mode_d);
            chg_q    <= (mode_d != mode_q);
        end
    end

    assign msg_sel     = mode_q;
    assign mode_onehot = onehot_q;
    assign mode_chg    = chg_q;

endmodule
`default_nettype wire

// File: tb/tb_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_mode_ctrl
// Brief  : Scoreboard bench for mode_ctrl (DEB_CYCLES=4, LONG_CYCLES=50)
// Rev    : 1.0
// ============================================================================
module tb_mode_ctrl;

    localparam int DEB  = 4;
    localparam int LONG = 50;
    localparam int LAT  = DEB + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic [1:0] msg_sel;
    logic [3:0] mode_onehot;
    logic       mode_chg;

    mode_ctrl #(.DEB_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_next    (btn_next),
        .btn_prev    (btn_prev),
        .msg_sel     (msg_sel),
        .mode_onehot (mode_onehot),
        .mode_chg    (mode_chg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int         cyc;
        logic [1:0] mode;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_err    = 0;
    int         n_pulses = 0;
    logic [1:0] exp_mode = 2'b00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int c, input logic [1:0] m);
        exp_t e;
        e.cyc  = c;
        e.mode = m;
        sb.push_back(e);
        exp_mode = m;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One press of next (nxt=1) or prev (nxt=0) held for 'hold' cycles.
    task automatic press(input bit nxt, input int hold);
        int k;
        @(negedge clk);
        k = cyc + 1;
        if (nxt) begin
            btn_next = 1'b1;
            push(k + LAT, 2'(exp_mode + 2'd1));
        end else begin
            btn_prev = 1'b1;
            push(k + LAT, 2'(exp_mode - 2'd1));
        end
        wait_cyc(hold);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        wait_cyc(12);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && mode_chg === 1'b1) begin
            n_pulses++;
            if (sb.size() == 0) begin
                chk("unexpected_mode_chg", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("chg_cycle", cyc, mon_e.cyc);
                chk("chg_msg_sel", {30'd0, msg_sel}, {30'd0, mon_e.mode});
                chk("chg_onehot", {28'd0, mode_onehot}, {28'd0, 4'b0001 << mon_e.mode});
            end
        end
    end

    initial begin
        int k;
        int r;
        int pulses_before;

        wait_cyc(3);
        chk("rst_msg_sel", {30'd0, msg_sel}, 32'd0);
        chk("rst_onehot", {28'd0, mode_onehot}, 32'd1);
        chk("rst_mode_chg", {31'd0, mode_chg}, 32'd0);
        rst = 1'b0;
        wait_cyc(8);
        chk("rst_hold_msg_sel", {30'd0, msg_sel}, 32'd0);

        repeat (4) press(1'b1, 20);
        chk("four_next_msg_sel", {30'd0, msg_sel}, 32'd0);
        chk("four_next_pulses", n_pulses, 32'd4);

        // Bounce: runs of 2 equal samples never reach DEB.
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            btn_next = ~btn_next;
            wait_cyc(2);
        end
        btn_next = 1'b0;
        wait_cyc(12);
        chk("bounce_msg_sel", {30'd0, msg_sel}, 32'd0);
        chk("bounce_pulses", n_pulses, 32'd4);

        press(1'b0, 20);
        chk("prev_wrap_msg_sel", {30'd0, msg_sel}, 32'd3);
        chk("prev_wrap_onehot", {28'd0, mode_onehot}, 32'd8);

        @(negedge clk);
        btn_next = 1'b1;
        btn_prev = 1'b1;
        wait_cyc(20);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        wait_cyc(12);
        chk("both_msg_sel", {30'd0, msg_sel}, 32'd3);
        chk("both_pulses", n_pulses, 32'd5);

        press(1'b0, 20);
        chk("to_timer_msg_sel", {30'd0, msg_sel}, 32'd2);

        // Long hold of next from TIMER.
        pulses_before = n_pulses;
        @(negedge clk);
        k = cyc + 1;
        btn_next = 1'b1;
        push(k + LAT, 2'b11);
`ifdef MODE_CTRL_LONG_HOME_EN
        push(k + DEB + 1 + LONG, 2'b00);
`endif
        wait_cyc(80);
        btn_next = 1'b0;
        wait_cyc(12);
`ifdef MODE_CTRL_LONG_HOME_EN
        chk("long_msg_sel", {30'd0, msg_sel}, 32'd0);
        chk("long_pulses", n_pulses - pulses_before, 32'd2);
`else
        chk("long_msg_sel", {30'd0, msg_sel}, 32'd3);
        chk("long_pulses", n_pulses - pulses_before, 32'd1);
`endif

        // Leave a non-WATCH mode so the asynchronous reset is observable.
        press(1'b0, 20);

        @(negedge clk);
        k = cyc + 1;
        btn_next = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_msg_sel", {30'd0, msg_sel}, 32'd0);
        chk("async_rst_onehot", {28'd0, mode_onehot}, 32'd1);
        chk("async_rst_mode_chg", {31'd0, mode_chg}, 32'd0);
        sb.delete();
        exp_mode = 2'b00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        r = cyc + 1;
        push(r + LAT, 2'b01);
        wait_cyc(20);
        btn_next = 1'b0;
        wait_cyc(12);
        chk("rst_hold_msg_sel_after", {30'd0, msg_sel}, 32'd1);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
